lcd_refresh_seq: RTL and testbench

HD44780-compatible character-LCD sequencer for the DE2 16x2 panel. Owns the LCD bus: it runs the power-on init sequence, then repeatedly copies a 32-byte on-chip character buffer to the display. Host logic (Nios PIO or fabric) only performs single-cycle buffer writes and never handles LCD timing.

---
 rtl/lcd_refresh_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_lcd_refresh_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_seq.sv
// HD44780 16x2 sequencer: power-on init, then repeated copies of a 32-byte buffer to the panel.
// Define LCD_REFRESH_DIRTY_EN to refresh only after buffer writes (IDLE between passes).
module lcd_refresh_seq #(
    parameter int unsigned E_PULSE  = 25,
    parameter int unsigned CMD_WAIT = 2500,
    parameter int unsigned CLR_WAIT = 100000,
    parameter int unsigned PWR_WAIT = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       frame_done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int unsigned MAX_A   = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int unsigned MAX_B   = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_WAIT - 1);
    localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(E_PULSE - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT - 1);

    typedef enum logic [2:0] {
        ST_PWR,
        ST_INIT,
        ST_ADDR0,
        ST_LINE0,
        ST_ADDR1,
        ST_LINE1
`ifdef LCD_REFRESH_DIRTY_EN
        , ST_IDLE
`endif
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EHIGH,
        PH_HOLD
    } phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [7:0]       mem_q [32];
    logic [7:0]       mem_d [32];
    logic             lcd_en_q, lcd_en_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             ready_q, ready_d;
    logic             frame_done_q, frame_done_d;
`ifdef LCD_REFRESH_DIRTY_EN
    logic             dirty_q, dirty_d;
`endif

    logic             launch;
    logic             hold_done;
    logic             clr_cmd;
    state_t           nxt_state;
    logic [4:0]       nxt_idx;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        lcd_en_d     = lcd_en_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;
        mem_d        = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        launch    = 1'b0;
        hold_done = 1'b0;
        nxt_state = state_q;
        nxt_idx   = idx_q;
        clr_cmd   = (state_q == ST_INIT) && (idx_q == 5'd3);

`ifdef LCD_REFRESH_DIRTY_EN
        // A write in the ADDR0 SETUP cycle wins over the clear, so it still gets its own pass.
        dirty_d = dirty_q;
        if ((state_q == ST_ADDR0) && (phase_q == PH_SETUP)) begin
            dirty_d = 1'b0;
        end
        if (wr_en) begin
            dirty_d = 1'b1;
        end
`endif

        case (state_q)
            ST_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    launch    = 1'b1;
                    nxt_state = ST_INIT;
                    nxt_idx   = 5'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef LCD_REFRESH_DIRTY_EN
            ST_IDLE: begin
                if (dirty_q) begin
                    launch    = 1'b1;
                    nxt_state = ST_ADDR0;
                    nxt_idx   = 5'd0;
                end
            end
`endif
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        lcd_en_d = 1'b1;
                        phase_d  = PH_EHIGH;
                        cnt_d    = '0;
                    end
                    PH_EHIGH: begin
                        if (cnt_q == E_LAST) begin
                            lcd_en_d = 1'b0;
                            phase_d  = PH_HOLD;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == (clr_cmd ? CLR_LAST : CMD_LAST)) begin
                            hold_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        endcase

        // The character index runs 0..31 across both lines and wraps only after LINE1.
        if (hold_done) begin
            launch = 1'b1;
            case (state_q)
                ST_INIT: begin
                    if (idx_q == 5'd3) begin
                        nxt_state = ST_ADDR0;
                        nxt_idx   = 5'd0;
                        ready_d   = 1'b1;
                    end else begin
                        nxt_idx = idx_q + 5'd1;
                    end
                end
                ST_ADDR0: nxt_state = ST_LINE0;
                ST_LINE0: begin
                    nxt_idx = idx_q + 5'd1;
                    if (idx_q == 5'd15) begin
                        nxt_state = ST_ADDR1;
                    end
                end
                ST_ADDR1: nxt_state = ST_LINE1;
                default: begin
                    nxt_idx = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        frame_done_d = 1'b1;
                        nxt_state    = ST_ADDR0;
`ifdef LCD_REFRESH_DIRTY_EN
                        launch  = 1'b0;
                        state_d = ST_IDLE;
                        idx_d   = 5'd0;
                        cnt_d   = '0;
`endif
                    end
                end
            endcase
        end

        // Next transfer's SETUP; a write landing on the same edge is forwarded.
        if (launch) begin
            state_d  = nxt_state;
            idx_d    = nxt_idx;
            phase_d  = PH_SETUP;
            cnt_d    = '0;
            lcd_en_d = 1'b0;
            case (nxt_state)
                ST_INIT: begin
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_cmd(nxt_idx[1:0]);
                end
                ST_ADDR0: begin
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = 8'h80;
                end
                ST_ADDR1: begin
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = 8'hC0;
                end
                default: begin
                    lcd_rs_d   = 1'b1;
                    lcd_data_d = (wr_en && (wr_addr == nxt_idx)) ? wr_data : mem_q[nxt_idx];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_PWR;
            phase_q      <= PH_SETUP;
            cnt_q        <= '0;
            idx_q        <= 5'd0;
            lcd_en_q     <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'h20;
            end
`ifdef LCD_REFRESH_DIRTY_EN
            dirty_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lcd_en_q     <= lcd_en_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            mem_q        <= mem_d;
`ifdef LCD_REFRESH_DIRTY_EN
            dirty_q      <= dirty_d;
`endif
        end
    end

    assign ready      = ready_q;
    assign frame_done = frame_done_q;
    assign lcd_en     = lcd_en_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_q;

endmodule

// File: tb/tb_lcd_refresh_seq.sv
// Directed bench for lcd_refresh_seq with E_PULSE=2, CMD_WAIT=4, CLR_WAIT=8, PWR_WAIT=16.
`timescale 1ns/1ps
module tb_lcd_refresh_seq;

    localparam int E_P  = 2;
    localparam int XFER = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       ready, frame_done, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int         cyc;
    int         n_chk = 0;
    int         n_err = 0;
    int         nfd   = 0;
    logic [8:0] rec_d [$];
    int         rec_c [$];
    logic [7:0] mem   [32];

    lcd_refresh_seq #(
        .E_PULSE (2),
        .CMD_WAIT(4),
        .CLR_WAIT(8),
        .PWR_WAIT(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ready     (ready),
        .frame_done(frame_done),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    // Edges since reset release; cyc==N means N rising edges have been seen.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus monitor: logs every E rise and checks setup, E width and data stability.
    initial begin : mon
        logic       en_prev;
        logic [8:0] d_prev;
        int         run;
        en_prev = 1'b0;
        d_prev  = '0;
        run     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                en_prev = 1'b0;
                run     = 0;
                d_prev  = {lcd_rs, lcd_data};
            end else begin
                if (lcd_en && !en_prev) begin
                    check("setup_before_en", {lcd_rs, lcd_data}, d_prev);
                    rec_d.push_back({lcd_rs, lcd_data});
                    rec_c.push_back(cyc);
                    run = 1;
                end else if (lcd_en) begin
                    check("data_stable_en", {lcd_rs, lcd_data}, d_prev);
                    run++;
                end else if (en_prev) begin
                    check("en_width", run, E_P);
                end
                if (frame_done === 1'b1) nfd++;
                en_prev = lcd_en;
                d_prev  = {lcd_rs, lcd_data};
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < n);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_frame(input int exp_cyc, input string tag);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (frame_done !== 1'b1 && k < 400);
        check(tag, (frame_done === 1'b1) ? cyc : -1, exp_cyc);
    endtask

    task automatic check_init();
        logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        if (rec_d.size() < 4) begin
            check("init_rec_count", rec_d.size(), 4);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init_cmd%0d", i), rec_d[i], {1'b0, cmds[i]});
            check($sformatf("init_en_cyc%0d", i), rec_c[i], 17 + XFER * i);
        end
    endtask

    task automatic check_pass(input int base, input int start, input string tag);
        logic [8:0] exp;
        int         bad_gap = 0;
        if (rec_d.size() < base + 34) begin
            check({tag, "_rec_count"}, rec_d.size(), base + 34);
            return;
        end
        check({tag, "_start"}, rec_c[base], start + 1);
        for (int j = 0; j < 34; j++) begin
            if (j == 0)       exp = {1'b0, 8'h80};
            else if (j <= 16) exp = {1'b1, mem[j-1]};
            else if (j == 17) exp = {1'b0, 8'hC0};
            else              exp = {1'b1, mem[j-2]};
            check($sformatf("%s_x%0d", tag, j), rec_d[base+j], exp);
            if (rec_c[base+j] != rec_c[base] + XFER * j) bad_gap++;
        end
        check({tag, "_spacing_errs"}, bad_gap, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h20;

        repeat (3) @(posedge clk);
        #1;
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_data", lcd_data, 8'h00);
        check("rst_ready", ready, 0);
        check("rst_frame_done", frame_done, 0);

        @(negedge clk) reset_n = 1'b1;
        wait_cyc(15);
        check("pwr_quiet_data", lcd_data, 8'h00);
        wait_cyc(16);
        check("first_setup_data", lcd_data, 8'h38);
        check("first_setup_rs", lcd_rs, 0);
        check("first_setup_en", lcd_en, 0);
        wait_cyc(17);
        check("first_en_rise", lcd_en, 1);

        wr(5'd0, 8'h41);
        mem[0] = 8'h41;
        wr(5'd31, 8'h42);
        mem[31] = 8'h42;

        wait_cyc(47);
        check("ready_before", ready, 0);
        wait_cyc(48);
        check("ready_rise", ready, 1);
        check("addr0_data", lcd_data, 8'h80);
        check("addr0_rs", lcd_rs, 0);

        wait_frame(286, "frame1_cyc");
        wait_cyc(287);
        check("frame1_one_cycle", frame_done, 0);
        check_init();
        check_pass(4, 48, "pass1");

`ifdef LCD_REFRESH_DIRTY_EN
        wait_cyc(1286);
        check("idle_quiet_recs", rec_d.size(), 38);
        check("idle_quiet_en", lcd_en, 0);
        wr(5'd7, 8'h37);
        mem[7] = 8'h37;
        wait_frame(1526, "frame2_cyc");
        check_pass(38, 1288, "pass2");
        wait_cyc(1800);
        check("idle_again_recs", rec_d.size(), 72);
        check("frame_count", nfd, 2);
        check("ready_held", ready, 1);
`else
        wait_cyc(328);
        check("coll_setup_data", lcd_data, 8'h20);
        check("coll_setup_rs", lcd_rs, 1);
        wr(5'd5, 8'h5A);

        wait_cyc(570);
        check_pass(38, 286, "pass2");
        check("pass3_char5", (rec_d.size() > 78) ? rec_d[78] : 9'h000, {1'b1, 8'h5A});
        check("frame_count", nfd, 2);
        check("ready_held", ready, 1);
        mem[5] = 8'h5A;

        wait_cyc(602);
        check("pre_reset_en", lcd_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_lcd_en", lcd_en, 0);
        check("midrst_ready", ready, 0);
        check("midrst_lcd_data", lcd_data, 8'h00);
        check("midrst_lcd_rs", lcd_rs, 0);
        rec_d.delete();
        rec_c.delete();
        nfd = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h20;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        wait_cyc(16);
        check("rerun_first_setup", lcd_data, 8'h38);
        wait_frame(286, "frame_after_rst_cyc");
        check_init();
        check_pass(4, 48, "pass_rst");
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
